cnn_layer_accel_weight_config_loader: RTL and testbench

- Upstream feeder for the per-CE weight tables. It accepts a valid/ready stream of 16-bit weight words from the job/interface side and writes them in order into CE0..CE(N-1).
- Each CE receives (num_kernels+1) kernels of C_KRNL_WORDS words. Per CE, the block drives config_mode, a one-hot write enable and a broadcast data bus.
- It pulses job_accept at job start so each table clears its kernel_idx/kernel_count, and it reports completion.

---
 rtl/cnn_layer_accel_pkg.sv | 30 +++
 rtl/cnn_layer_accel_nested_counter.sv | 58 +++++
 rtl/cnn_layer_accel_weight_config_loader.sv | 145 ++++++++++++++
 tb/tb_cnn_layer_accel_weight_config_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CNN layer accelerator configuration path.
// Holds the loader state encoding, the 3x3 kernel geometry and derived counter widths.
package cnn_layer_accel_pkg;

    localparam int C_NUM_CE_DEF           = 8;
    localparam int C_KRNL_WORDS_3x3       = 9;
    localparam int C_CLG2_MAX_KERNELS_DEF = 5;
    localparam int C_WORD_WIDTH_DEF       = 16;

    localparam int C_CLG2_KRNL_WORDS = $clog2(C_KRNL_WORDS_3x3);
    localparam int C_CLG2_NUM_CE     = $clog2(C_NUM_CE_DEF);
    // One extra bit so an out-of-range CE count reaches the clamp instead of aliasing.
    localparam int C_CE_SEL_W        = $clog2(C_NUM_CE_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_LOAD   = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_t;

    typedef struct packed {
        loader_state_t                     state;
        logic [C_CE_SEL_W-1:0]             ce_cnt;
        logic [C_CLG2_MAX_KERNELS_DEF-1:0] krnl_cnt;
        logic [C_CLG2_KRNL_WORDS-1:0]      word_cnt;
        logic [2:0]                        wrap;
    } loader_dbg_t;

endpackage

// File: rtl/cnn_layer_accel_nested_counter.sv
// Three-level nested counter: level 0 is innermost, each level advances when all inner levels wrap.
// o_wrap[n] is high when levels 0..n are all at their limits; o_last equals o_wrap[2].
module cnn_layer_accel_nested_counter #(
    parameter int C_W0 = 4,
    parameter int C_W1 = 5,
    parameter int C_W2 = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_inc,
    input  logic [C_W0-1:0] i_lim0,
    input  logic [C_W1-1:0] i_lim1,
    input  logic [C_W2-1:0] i_lim2,
    output logic [C_W0-1:0] o_cnt0,
    output logic [C_W1-1:0] o_cnt1,
    output logic [C_W2-1:0] o_cnt2,
    output logic [2:0]      o_wrap,
    output logic            o_last
);

    logic [C_W0-1:0] r_cnt0;
    logic [C_W1-1:0] r_cnt1;
    logic [C_W2-1:0] r_cnt2;
    logic            w_at0;
    logic            w_at1;
    logic            w_at2;

    assign w_at0 = (r_cnt0 == i_lim0);
    assign w_at1 = (r_cnt1 == i_lim1);
    assign w_at2 = (r_cnt2 == i_lim2);

    assign o_wrap[0] = w_at0;
    assign o_wrap[1] = w_at0 && w_at1;
    assign o_wrap[2] = w_at0 && w_at1 && w_at2;
    assign o_last    = o_wrap[2];

    assign o_cnt0 = r_cnt0;
    assign o_cnt1 = r_cnt1;
    assign o_cnt2 = r_cnt2;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else if (i_inc) begin
            r_cnt0 <= w_at0 ? '0 : r_cnt0 + 1'b1;
            if (o_wrap[0]) begin
                r_cnt1 <= w_at1 ? '0 : r_cnt1 + 1'b1;
            end
            if (o_wrap[1]) begin
                r_cnt2 <= w_at2 ? '0 : r_cnt2 + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_layer_accel_weight_config_loader.sv
// Streams weight words into the per-CE weight tables: CE-major, then kernel, then word order.
// Handshake: a word transfers on a clk_core edge where wht_in_valid && wht_in_ready; it appears on wren/data one cycle later.
module cnn_layer_accel_weight_config_loader
    import cnn_layer_accel_pkg::*;
#(
    parameter int C_NUM_CE           = C_NUM_CE_DEF,
    parameter int C_KRNL_WORDS       = C_KRNL_WORDS_3x3,
    parameter int C_CLG2_MAX_KERNELS = C_CLG2_MAX_KERNELS_DEF,
    parameter int C_WORD_WIDTH       = C_WORD_WIDTH_DEF
) (
    input  logic                          clk_core,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic [C_CLG2_MAX_KERNELS-1:0] num_kernels,
    input  logic [C_CE_SEL_W-1:0]         num_ce_m1,
    input  logic                          wht_in_valid,
    input  logic [C_WORD_WIDTH-1:0]       wht_in_data,
    output logic                          wht_in_ready,
    output logic                          config_mode,
    output logic                          job_accept,
    output logic [C_NUM_CE-1:0]           wht_config_wren,
    output logic [C_WORD_WIDTH-1:0]       wht_config_data,
    output logic                          cfg_busy,
    output logic                          cfg_done,
    output loader_dbg_t                   dbg
);

    localparam int C_WORD_W = $clog2(C_KRNL_WORDS);

    loader_state_t                   r_state;
    logic [C_CLG2_MAX_KERNELS-1:0]   r_num_kernels;
    logic [C_CE_SEL_W-1:0]           r_num_ce_m1;
    logic                            r_ready;
    logic                            r_config_mode;
    logic                            r_job_accept;
    logic                            r_busy;
    logic                            r_done;
    logic [C_NUM_CE-1:0]             r_wren;
    logic [C_WORD_WIDTH-1:0]         r_data;

    logic                            w_start;
    logic                            w_hs;
    logic                            w_last;
    logic [2:0]                      w_wrap;
    logic [C_WORD_W-1:0]             w_word_cnt;
    logic [C_CLG2_MAX_KERNELS-1:0]   w_krnl_cnt;
    logic [C_CE_SEL_W-1:0]           w_ce_cnt;
    logic [C_CE_SEL_W-1:0]           w_ce_clamped;
    logic [C_NUM_CE-1:0]             w_onehot;

    assign w_start = (r_state == ST_IDLE) && cfg_start;
    assign w_hs    = wht_in_valid && r_ready;

    assign w_ce_clamped = (num_ce_m1 >= C_CE_SEL_W'(C_NUM_CE)) ? C_CE_SEL_W'(C_NUM_CE - 1) : num_ce_m1;
    assign w_onehot     = {{(C_NUM_CE-1){1'b0}}, 1'b1} << w_ce_cnt;

    cnn_layer_accel_nested_counter #(
        .C_W0 (C_WORD_W),
        .C_W1 (C_CLG2_MAX_KERNELS),
        .C_W2 (C_CE_SEL_W)
    ) u_cnt (
        .clk    (clk_core),
        .rst    (rst),
        .i_clr  (w_start),
        .i_inc  (w_hs),
        .i_lim0 (C_WORD_W'(C_KRNL_WORDS - 1)),
        .i_lim1 (r_num_kernels),
        .i_lim2 (r_num_ce_m1),
        .o_cnt0 (w_word_cnt),
        .o_cnt1 (w_krnl_cnt),
        .o_cnt2 (w_ce_cnt),
        .o_wrap (w_wrap),
        .o_last (w_last)
    );

    always_ff @(posedge clk_core) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_num_kernels <= '0;
            r_num_ce_m1   <= '0;
            r_ready       <= 1'b0;
            r_config_mode <= 1'b0;
            r_job_accept  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_wren        <= '0;
            r_data        <= '0;
        end else begin
            r_job_accept <= 1'b0;
            r_done       <= 1'b0;
            r_wren       <= '0;
            if (w_hs) begin
                r_wren <= w_onehot;
                r_data <= wht_in_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        r_num_kernels <= num_kernels;
                        r_num_ce_m1   <= w_ce_clamped;
                        r_state       <= ST_ACCEPT;
                        r_job_accept  <= 1'b1;
                        r_config_mode <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ST_ACCEPT: begin
                    r_state <= ST_LOAD;
                    r_ready <= 1'b1;
                end
                ST_LOAD: begin
                    // The final word's wren lands in DONE alongside cfg_done.
                    if (w_hs && w_last) begin
                        r_state <= ST_DONE;
                        r_ready <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state       <= ST_IDLE;
                    r_config_mode <= 1'b0;
                    r_busy        <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wht_in_ready    = r_ready;
    assign config_mode     = r_config_mode;
    assign job_accept      = r_job_accept;
    assign wht_config_wren = r_wren;
    assign wht_config_data = r_data;
    assign cfg_busy        = r_busy;
    assign cfg_done        = r_done;

    assign dbg.state    = r_state;
    assign dbg.ce_cnt   = C_CE_SEL_W'(w_ce_cnt);
    assign dbg.krnl_cnt = C_CLG2_MAX_KERNELS_DEF'(w_krnl_cnt);
    assign dbg.word_cnt = C_CLG2_KRNL_WORDS'(w_word_cnt);
    assign dbg.wrap     = w_wrap;

endmodule

// File: tb/tb_cnn_layer_accel_weight_config_loader.sv
// Directed bench for the weight config loader: a word-index model predicts every wren/data/done beat.
// Job-level literal counts pin the model against hand-computed totals.
module tb_cnn_layer_accel_weight_config_loader;
    import cnn_layer_accel_pkg::*;

    localparam int NCE = 8;
    localparam int KW  = 9;
    localparam int KB  = 5;
    localparam int WW  = 16;
    localparam int CEW = C_CE_SEL_W;

    // clock / reset
    logic          clk_core = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic [KB-1:0] num_kernels = '0;
    logic [CEW-1:0] num_ce_m1 = '0;
    logic          wht_in_valid = 1'b0;
    logic [WW-1:0] wht_in_data = '0;
    logic          wht_in_ready;
    logic          config_mode;
    logic          job_accept;
    logic [NCE-1:0] wht_config_wren;
    logic [WW-1:0] wht_config_data;
    logic          cfg_busy;
    logic          cfg_done;
    loader_dbg_t   dbg;

    always #5 clk_core = ~clk_core;

    cnn_layer_accel_weight_config_loader dut (
        .clk_core        (clk_core),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .num_kernels     (num_kernels),
        .num_ce_m1       (num_ce_m1),
        .wht_in_valid    (wht_in_valid),
        .wht_in_data     (wht_in_data),
        .wht_in_ready    (wht_in_ready),
        .config_mode     (config_mode),
        .job_accept      (job_accept),
        .wht_config_wren (wht_config_wren),
        .wht_config_data (wht_config_data),
        .cfg_busy        (cfg_busy),
        .cfg_done        (cfg_done),
        .dbg             (dbg)
    );

    int vectors = 0;
    int miscompares = 0;

    // model: entry = {last, ce[3:0], data[15:0]}
    logic [20:0] exp_q[$];
    int m_nk, m_nce, m_total, m_k;
    int wren_cnt[NCE];
    int wren_total, accept_cnt, done_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard
    always @(negedge clk_core) begin
        logic [20:0]    e;
        logic [NCE-1:0] one;
        one = 1;
        if (job_accept) accept_cnt++;
        if (cfg_done) done_cnt++;
        chk("accept_done_excl", 32'(job_accept & cfg_done), 32'd0);
        if (wht_config_wren != '0) begin
            wren_total++;
            for (int i = 0; i < NCE; i++) wren_cnt[i] += int'(wht_config_wren[i]);
            if (exp_q.size() == 0) begin
                chk("unexpected_wren", 32'(wht_config_wren), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wren_onehot", 32'(wht_config_wren), 32'(one << e[19:16]));
                chk("wren_data", 32'(wht_config_data), 32'(e[15:0]));
                chk("done_on_last", 32'(cfg_done), 32'(e[20]));
            end
        end else begin
            chk("done_without_wren", 32'(cfg_done), 32'd0);
        end
    end

    // driver tasks
    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(wht_in_ready), 32'd0);
        chk({tag, "_cfgmode"}, 32'(config_mode), 32'd0);
        chk({tag, "_accept"}, 32'(job_accept), 32'd0);
        chk({tag, "_wren"}, 32'(wht_config_wren), 32'd0);
        chk({tag, "_data"}, 32'(wht_config_data), 32'd0);
        chk({tag, "_busy"}, 32'(cfg_busy), 32'd0);
        chk({tag, "_done"}, 32'(cfg_done), 32'd0);
        chk({tag, "_state"}, 32'(dbg.state), 32'(ST_IDLE));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_core);
        @(negedge clk_core);
        check_all_zero("reset");
        chk("reset_cnts", 32'({dbg.ce_cnt, dbg.krnl_cnt, dbg.word_cnt}), 32'd0);
        rst = 1'b0;
        @(posedge clk_core); #1;
    endtask

    task automatic start_job(input int nk, input int cem1);
        num_kernels = KB'(nk);
        num_ce_m1   = CEW'(cem1);
        cfg_start   = 1'b1;
        @(posedge clk_core); #1;
        cfg_start = 1'b0;
        m_nk    = nk;
        m_nce   = (cem1 >= NCE) ? NCE : cem1 + 1;
        m_total = KW * (nk + 1) * m_nce;
        m_k     = 0;
        foreach (wren_cnt[i]) wren_cnt[i] = 0;
        wren_total = 0;
        accept_cnt = 0;
        done_cnt   = 0;
        @(negedge clk_core);
        chk("accept_pulse", 32'(job_accept), 32'd1);
        chk("accept_cfgmode", 32'(config_mode), 32'd1);
        chk("accept_busy", 32'(cfg_busy), 32'd1);
        chk("accept_ready", 32'(wht_in_ready), 32'd0);
        chk("accept_cnts", 32'({dbg.ce_cnt, dbg.krnl_cnt, dbg.word_cnt}), 32'd0);
    endtask

    task automatic send_word(input logic [WW-1:0] d);
        int   t;
        logic rdy;
        t = 0;
        wht_in_valid = 1'b1;
        wht_in_data  = d;
        do begin
            @(negedge clk_core);
            rdy = wht_in_ready;
            @(posedge clk_core); #1;
            t++;
        end while (!rdy && t < 50);
        wht_in_valid = 1'b0;
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles, expected 1", t);
        end else begin
            exp_q.push_back({(m_k == m_total - 1), 4'(m_k / (KW * (m_nk + 1))), d});
            m_k++;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk_core); #1;
        end
    endtask

    task automatic finish_job();
        @(negedge clk_core); #1;
        chk("done_cycle_cnt", 32'(done_cnt), 32'd1);
        chk("done_cycle_cfgmode", 32'(config_mode), 32'd1);
        chk("done_cycle_ready", 32'(wht_in_ready), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk_core);
        chk("idle_cfgmode", 32'(config_mode), 32'd0);
        chk("idle_busy", 32'(cfg_busy), 32'd0);
        chk("idle_state", 32'(dbg.state), 32'(ST_IDLE));
        chk("accept_cnt", 32'(accept_cnt), 32'd1);
        for (int i = 0; i < NCE; i++)
            chk("per_ce_words", 32'(wren_cnt[i]), (i < m_nce) ? 32'(KW * (m_nk + 1)) : 32'd0);
        @(posedge clk_core); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // single CE, single kernel
        start_job(0, 0);
        for (int i = 1; i <= 9; i++) send_word(WW'(i));
        finish_job();
        chk("t1_wren0_cycles", 32'(wren_cnt[0]), 32'd9);
        chk("t1_total", 32'(wren_total), 32'd9);

        // 2 kernels x 3 CEs back-to-back
        start_job(1, 2);
        for (int i = 0; i < 54; i++) send_word(WW'(16'h0100 + i));
        finish_job();
        chk("t2_ce0", 32'(wren_cnt[0]), 32'd18);
        chk("t2_ce1", 32'(wren_cnt[1]), 32'd18);
        chk("t2_ce2", 32'(wren_cnt[2]), 32'd18);
        chk("t2_ce3", 32'(wren_cnt[3]), 32'd0);

        // same job with random valid gaps
        start_job(1, 2);
        for (int i = 0; i < 54; i++) begin
            idle_cycles($urandom_range(0, 1));
            send_word(WW'(16'h0200 + i));
        end
        finish_job();
        chk("t3_total", 32'(wren_total), 32'd54);

        // cfg_start pulsed mid-load is ignored
        start_job(1, 2);
        for (int i = 0; i < 54; i++) begin
            if (i == 10) begin
                cfg_start = 1'b1;
                send_word(WW'(16'h0300 + i));
                cfg_start = 1'b0;
            end else begin
                send_word(WW'(16'h0300 + i));
            end
        end
        finish_job();
        chk("t4_single_accept", 32'(accept_cnt), 32'd1);

        // reset during load, then a clean restart
        start_job(1, 2);
        for (int i = 0; i < 20; i++) send_word(WW'(16'h0400 + i));
        rst = 1'b1;
        @(posedge clk_core);
        @(negedge clk_core);
        check_all_zero("midrst");
        chk("midrst_partial", 32'(wren_total), 32'd20);
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        @(posedge clk_core); #1;
        start_job(1, 2);
        for (int i = 0; i < 54; i++) send_word(WW'(16'h0500 + i));
        finish_job();
        chk("t5_restart_total", 32'(wren_total), 32'd54);

        // out-of-range CE count clamps to 8 CEs
        start_job(0, 9);
        for (int i = 0; i < 72; i++) send_word(WW'(16'h0600 + i));
        finish_job();
        chk("t6_total", 32'(wren_total), 32'd72);
        chk("t6_ce7", 32'(wren_cnt[7]), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
